// File: rtl/ap_hs_perf_recorder.sv
// ap_hs_perf_recorder: per-transaction latency/interval recorder for ap_ctrl_hs.
// Optional stall counting is built when AP_HS_PERF_STALL_EN is defined.
module ap_hs_perf_recorder #(
  parameter int TS_W    = 32,
  parameter int MAX_OUT = 4,
  parameter int DEPTH   = 16
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  input  logic            mon_start,
  input  logic            mon_ready,
  input  logic            mon_done,
  input  logic            enable,
  input  logic            clear,
  output logic            rec_valid,
  input  logic            rec_ready,
  output logic [TS_W-1:0] rec_latency,
  output logic [TS_W-1:0] rec_interval,
  output logic [TS_W-1:0] rec_stall,
  output logic [15:0]     drop_cnt,
  output logic [15:0]     orphan_cnt,
  output logic            busy
);

  localparam int QA = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int QC = $clog2(MAX_OUT + 1);
  localparam int FA = $clog2(DEPTH);
  localparam int FC = $clog2(DEPTH + 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t          state;
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] last_ts;
  logic            first;

  logic [TS_W-1:0] q_ts  [MAX_OUT];
  logic [TS_W-1:0] q_int [MAX_OUT];
  logic [QA-1:0]   q_wp;
  logic [QA-1:0]   q_rp;
  logic [QC-1:0]   q_cnt;

  logic [TS_W-1:0] f_lat [DEPTH];
  logic [TS_W-1:0] f_int [DEPTH];
  logic [FA-1:0]   f_wp;
  logic [FA-1:0]   f_rp;
  logic [FC-1:0]   f_cnt;

  logic            acc_req;
  logic            dn;
  logic            q_empty;
  logic            q_full;
  logic            q_push;
  logic            q_pop;
  logic            acc_drop;
  logic            orphan;
  logic            f_full;
  logic            f_push;
  logic            f_pop;
  logic            rec_drop;
  logic [TS_W-1:0] new_int;
  logic [TS_W-1:0] pop_lat;
  logic [1:0]      drop_inc;
  logic [16:0]     drop_sum;

  function automatic logic [QA-1:0] q_nxt(
    input logic [QA-1:0] p
  );
    return (p == QA'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [FA-1:0] f_nxt(
    input logic [FA-1:0] p
  );
    return (p == FA'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Event decode; a pop in the same cycle frees queue space for an accept
  always_comb begin
    acc_req  = mon_start & mon_ready & enable;
    dn       = mon_done & enable;
    q_empty  = (q_cnt == '0);
    q_full   = (q_cnt == QC'(MAX_OUT));
    q_pop    = dn & ~q_empty;
    q_push   = acc_req & (~q_full | q_pop);
    acc_drop = acc_req & ~q_push;
    orphan   = dn & q_empty;
    rec_valid = (f_cnt != '0);
    f_full   = (f_cnt == FC'(DEPTH));
    f_pop    = rec_valid & rec_ready;
    f_push   = q_pop & (~f_full | f_pop);
    rec_drop = q_pop & ~f_push;
    new_int  = first ? '0 : ts - last_ts;
    pop_lat  = ts - q_ts[q_rp];
    drop_inc = {1'b0, acc_drop} + {1'b0, rec_drop};
    drop_sum = {1'b0, drop_cnt} + {15'd0, drop_inc};
  end

  // Free-running timestamp and last-accept tracking
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ts      <= '0;
      last_ts <= '0;
      first   <= 1'b1;
    end else if (clear) begin
      ts      <= '0;
      last_ts <= '0;
      first   <= 1'b1;
    end else begin
      ts <= ts + 1'b1;
      if (q_push) begin
        last_ts <= ts;
        first   <= 1'b0;
      end
    end
  end

  // Start queue storage; pointers alone define validity
  always_ff @(posedge ap_clk) begin
    if (q_push) begin
      q_ts[q_wp]  <= ts;
      q_int[q_wp] <= new_int;
    end
  end

  // Start queue pointers and occupancy
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      q_wp  <= '0;
      q_rp  <= '0;
      q_cnt <= '0;
    end else if (clear) begin
      q_wp  <= '0;
      q_rp  <= '0;
      q_cnt <= '0;
    end else begin
      if (q_push) q_wp <= q_nxt(q_wp);
      if (q_pop)  q_rp <= q_nxt(q_rp);
      if (q_push && !q_pop)
        q_cnt <= q_cnt + 1'b1;
      else if (q_pop && !q_push)
        q_cnt <= q_cnt - 1'b1;
    end
  end

  // Record FIFO storage
  always_ff @(posedge ap_clk) begin
    if (f_push) begin
      f_lat[f_wp] <= pop_lat;
      f_int[f_wp] <= q_int[q_rp];
    end
  end

  // Record FIFO pointers and occupancy
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      f_wp  <= '0;
      f_rp  <= '0;
      f_cnt <= '0;
    end else if (clear) begin
      f_wp  <= '0;
      f_rp  <= '0;
      f_cnt <= '0;
    end else begin
      if (f_push) f_wp <= f_nxt(f_wp);
      if (f_pop)  f_rp <= f_nxt(f_rp);
      if (f_push && !f_pop)
        f_cnt <= f_cnt + 1'b1;
      else if (f_pop && !f_push)
        f_cnt <= f_cnt - 1'b1;
    end
  end

  // Saturating drop and orphan counters
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      drop_cnt   <= '0;
      orphan_cnt <= '0;
    end else if (clear) begin
      drop_cnt   <= '0;
      orphan_cnt <= '0;
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hffff : drop_sum[15:0];
      if (orphan && orphan_cnt != 16'hffff)
        orphan_cnt <= orphan_cnt + 1'b1;
    end
  end

  // Transaction FSM: busy while any accept is outstanding
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= S_IDLE;
    end else if (clear) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (q_push) state <= S_BUSY;
        S_BUSY: begin
          if (q_pop && !q_push && q_cnt == QC'(1))
            state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == S_BUSY);

  assign rec_latency  = rec_valid ? f_lat[f_rp] : '0;
  assign rec_interval = rec_valid ? f_int[f_rp] : '0;

`ifdef AP_HS_PERF_STALL_EN
  logic [TS_W-1:0] stall_cnt;
  logic [TS_W-1:0] q_st [MAX_OUT];
  logic [TS_W-1:0] f_st [DEPTH];

  // Stall cycles accumulated toward the next accept
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stall_cnt <= '0;
    end else if (clear) begin
      stall_cnt <= '0;
    end else if (acc_req) begin
      stall_cnt <= '0;
    end else if (mon_start && !mon_ready && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // Stall value travels with its queue entry into the record
  always_ff @(posedge ap_clk) begin
    if (q_push) q_st[q_wp] <= stall_cnt;
    if (f_push) f_st[f_wp] <= q_st[q_rp];
  end

  assign rec_stall = rec_valid ? f_st[f_rp] : '0;
`else
  assign rec_stall = '0;
`endif

endmodule

// File: tb/tb_ap_hs_perf_recorder.sv
// tb_ap_hs_perf_recorder: directed bench for ap_hs_perf_recorder.
// A TS_W=8 instance shares the stimulus to exercise timestamp wrap.
module tb_ap_hs_perf_recorder;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        mon_start;
  logic        mon_ready;
  logic        mon_done;
  logic        enable;
  logic        clear;
  logic        rec_ready;

  logic        rec_valid;
  logic [31:0] rec_latency;
  logic [31:0] rec_interval;
  logic [31:0] rec_stall;
  logic [15:0] drop_cnt;
  logic [15:0] orphan_cnt;
  logic        busy;

  logic        w8_valid;
  logic [7:0]  w8_latency;
  logic [7:0]  w8_interval;
  logic [7:0]  w8_stall;
  logic [15:0] w8_drop;
  logic [15:0] w8_orphan;
  logic        w8_busy;

  int checks   = 0;
  int failures = 0;
  int tnow     = 0;

  int exp_lat [17];
  int exp_int [17];
  int t_a;
  int prev_a;

  always #5 ap_clk = ~ap_clk;

  ap_hs_perf_recorder #(
    .TS_W(32), .MAX_OUT(4), .DEPTH(16)
  ) u_dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .mon_start(mon_start),
    .mon_ready(mon_ready),
    .mon_done(mon_done),
    .enable(enable),
    .clear(clear),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_latency(rec_latency),
    .rec_interval(rec_interval),
    .rec_stall(rec_stall),
    .drop_cnt(drop_cnt),
    .orphan_cnt(orphan_cnt),
    .busy(busy)
  );

  ap_hs_perf_recorder #(
    .TS_W(8), .MAX_OUT(4), .DEPTH(16)
  ) u_w8 (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .mon_start(mon_start),
    .mon_ready(mon_ready),
    .mon_done(mon_done),
    .enable(enable),
    .clear(clear),
    .rec_valid(w8_valid),
    .rec_ready(rec_ready),
    .rec_latency(w8_latency),
    .rec_interval(w8_interval),
    .rec_stall(w8_stall),
    .drop_cnt(w8_drop),
    .orphan_cnt(w8_orphan),
    .busy(w8_busy)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
    tnow++;
  endtask

  task automatic run_to(input int t);
    while (tnow < t) step();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    tnow  = 0;
  endtask

  task automatic accept();
    mon_start = 1'b1;
    mon_ready = 1'b1;
    step();
    mon_start = 1'b0;
    mon_ready = 1'b0;
  endtask

  task automatic done();
    mon_done = 1'b1;
    step();
    mon_done = 1'b0;
  endtask

  task automatic pop();
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
  endtask

  initial begin
    ap_rst_n  = 1'b0;
    mon_start = 1'b0;
    mon_ready = 1'b0;
    mon_done  = 1'b0;
    enable    = 1'b1;
    clear     = 1'b0;
    rec_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(rec_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_orphan", 32'(orphan_cnt), 32'd0);
    chk("rst_lat", rec_latency, 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    step();

    // single transaction: accept@10, done@45
    do_clear();
    run_to(10);
    accept();
    chk("t1_busy", 32'(busy), 32'd1);
    run_to(45);
    chk("t1_pre_valid", 32'(rec_valid), 32'd0);
    done();
    chk("t1_valid", 32'(rec_valid), 32'd1);
    chk("t1_lat", rec_latency, 32'd35);
    chk("t1_int", rec_interval, 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);
    step();
    chk("t1_hold_lat", rec_latency, 32'd35);
    pop();
    chk("t1_empty", 32'(rec_valid), 32'd0);

    // back-to-back: accepts 5,9,13; dones 20,24,28
    do_clear();
    run_to(5);  accept();
    run_to(9);  accept();
    run_to(13); accept();
    run_to(20); done();
    run_to(24); done();
    run_to(28); done();
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_lat0", rec_latency, 32'd15);
    chk("t2_int0", rec_interval, 32'd0);
    pop();
    chk("t2_lat1", rec_latency, 32'd15);
    chk("t2_int1", rec_interval, 32'd4);
    pop();
    chk("t2_lat2", rec_latency, 32'd15);
    chk("t2_int2", rec_interval, 32'd4);
    pop();
    chk("t2_empty", 32'(rec_valid), 32'd0);

    // orphan done, then start-queue overflow
    do_clear();
    done();
    chk("t3_orphan", 32'(orphan_cnt), 32'd1);
    chk("t3_norec", 32'(rec_valid), 32'd0);
    mon_start = 1'b1;
    mon_ready = 1'b1;
    repeat (5) step();
    mon_start = 1'b0;
    mon_ready = 1'b0;
    chk("t3_drop", 32'(drop_cnt), 32'd1);
    chk("t3_busy", 32'(busy), 32'd1);
    do_clear();
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    chk("clr_orphan", 32'(orphan_cnt), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);

    // enable low: no queue activity
    enable = 1'b0;
    accept();
    done();
    chk("en_busy", 32'(busy), 32'd0);
    chk("en_orphan", 32'(orphan_cnt), 32'd0);
    chk("en_valid", 32'(rec_valid), 32'd0);
    enable = 1'b1;

    // backpressure: 17 transactions into a 16-deep FIFO
    do_clear();
    prev_a = 0;
    for (int i = 0; i < 17; i++) begin
      t_a = tnow;
      accept();
      repeat (i) step();
      exp_lat[i] = tnow - t_a;
      exp_int[i] = (i == 0) ? 0 : t_a - prev_a;
      prev_a = t_a;
      done();
    end
    chk("t4_drop", 32'(drop_cnt), 32'd1);
    rec_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t4_valid", 32'(rec_valid), 32'd1);
      chk("t4_lat", rec_latency, 32'(exp_lat[i]));
      chk("t4_int", rec_interval, 32'(exp_int[i]));
      step();
    end
    rec_ready = 1'b0;
    chk("t4_empty", 32'(rec_valid), 32'd0);

    // stall attribution
    do_clear();
    mon_start = 1'b1;
    mon_ready = 1'b0;
    repeat (7) step();
    accept();
    step();
    done();
    chk("t6_lat", rec_latency, 32'd2);
`ifdef AP_HS_PERF_STALL_EN
    chk("t6_stall", rec_stall, 32'd7);
`else
    chk("t6_stall", rec_stall, 32'd0);
`endif
    pop();

    // timestamp wrap on the 8-bit instance: accept@250, done@260 (ts=4)
    do_clear();
    run_to(250);
    accept();
    run_to(260);
    done();
    chk("t5_w8_valid", 32'(w8_valid), 32'd1);
    chk("t5_w8_lat", 32'(w8_latency), 32'd10);
    chk("t5_lat", rec_latency, 32'd10);

    // async reset mid-transaction
    accept();
    chk("t5_pre_busy", 32'(busy), 32'd1);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(rec_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_lat", rec_latency, 32'd0);
    chk("t5_rst_w8_valid", 32'(w8_valid), 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    step();
    done();
    chk("t5_post_orphan", 32'(orphan_cnt), 32'd1);
    chk("t5_post_valid", 32'(rec_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
